// File: rtl/alu_pkg.sv
// Shared ALU select codes, opcode/funct constants and control-bit positions
// for the ID/EX stage and its decoder.
package alu_pkg;

   // ALU operation select presented to the EX-stage ALU
   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_SUB     = 4'b0110,
      ALU_SLT     = 4'b0111,
      ALU_NOR     = 4'b1100,
      ALU_INVALID = 4'b1111
   } alu_op_t;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   // Bit positions in id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src}
   localparam int unsigned CTRL_REG_WRITE  = 5;
   localparam int unsigned CTRL_MEM_READ   = 4;
   localparam int unsigned CTRL_MEM_WRITE  = 3;
   localparam int unsigned CTRL_MEM_TO_REG = 2;
   localparam int unsigned CTRL_REG_DST    = 1;
   localparam int unsigned CTRL_ALU_SRC    = 0;

   // Bit positions in the registered ex_ctrl = {reg_write, mem_read, mem_write, mem_to_reg}
   localparam int unsigned EX_CTRL_REG_WRITE  = 3;
   localparam int unsigned EX_CTRL_MEM_READ   = 2;
   localparam int unsigned EX_CTRL_MEM_WRITE  = 1;
   localparam int unsigned EX_CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: opcode/funct to ALU select plus
// illegal, branch, zero-extend and rt-usage flags.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_op_t    alu_sel,
   output logic       illegal,
   output logic       branch,
   output logic       zero_ext,
   output logic       uses_rt
);

   // Decode; anything not recognised falls through to the invalid select
   always_comb begin
      alu_sel  = ALU_INVALID;
      illegal  = 1'b1;
      branch   = 1'b0;
      zero_ext = 1'b0;
      uses_rt  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            uses_rt = 1'b1;
            case (funct)
               FN_ADD:  begin alu_sel = ALU_ADD; illegal = 1'b0; end
               FN_SUB:  begin alu_sel = ALU_SUB; illegal = 1'b0; end
               FN_AND:  begin alu_sel = ALU_AND; illegal = 1'b0; end
               FN_OR:   begin alu_sel = ALU_OR;  illegal = 1'b0; end
               FN_SLT:  begin alu_sel = ALU_SLT; illegal = 1'b0; end
               FN_NOR:  begin alu_sel = ALU_NOR; illegal = 1'b0; end
               default: ;
            endcase
         end
         OP_LW, OP_ADDI: begin
            alu_sel = ALU_ADD;
            illegal = 1'b0;
         end
         OP_SW: begin
            alu_sel = ALU_ADD;
            illegal = 1'b0;
            uses_rt = 1'b1;
         end
         OP_BEQ: begin
            alu_sel = ALU_SUB;
            illegal = 1'b0;
            branch  = 1'b1;
            uses_rt = 1'b1;
         end
         OP_ANDI: begin
            alu_sel  = ALU_AND;
            illegal  = 1'b0;
            zero_ext = 1'b1;
         end
         OP_ORI: begin
            alu_sel  = ALU_OR;
            illegal  = 1'b0;
            zero_ext = 1'b1;
         end
         OP_SLTI: begin
            alu_sel = ALU_SLT;
            illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_ex_alu_feed.sv
// ID/EX pipeline register feeding the EX-stage ALU: decodes the ALU select,
// extends the immediate, forwards from EX/MEM and MEM/WB, and detects
// load-use hazards. Supports stall (hold) and flush (bubble).
module id_ex_alu_feed
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm16,
   input  logic [5:0]        id_ctrl,
   input  logic              stall,
   input  logic              flush,
   input  logic              exm_wr_en,
   input  logic [REG_AW-1:0] exm_wr_addr,
   input  logic [DATA_W-1:0] exm_wr_data,
   input  logic              mwb_wr_en,
   input  logic [REG_AW-1:0] mwb_wr_addr,
   input  logic [DATA_W-1:0] mwb_wr_data,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [3:0]        ex_alu_sel,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_dest,
   output logic [3:0]        ex_ctrl,
   output logic              ex_branch,
   output logic              ex_illegal
);

   alu_op_t           dec_sel;
   logic              dec_illegal;
   logic              dec_branch;
   logic              dec_zero_ext;
   logic              dec_uses_rt;

   logic [DATA_W-1:0] id_imm_ext;
   logic [REG_AW-1:0] id_dest;

   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic              ex_alu_src;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   logic              load_bubble;

   alu_ctrl_dec u_dec (
      .opcode   (id_opcode),
      .funct    (id_funct),
      .alu_sel  (dec_sel),
      .illegal  (dec_illegal),
      .branch   (dec_branch),
      .zero_ext (dec_zero_ext),
      .uses_rt  (dec_uses_rt)
   );

   // Immediate extension and destination select at ID
   always_comb begin
      id_imm_ext = dec_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm16}
                                : {{(DATA_W-16){id_imm16[15]}}, id_imm16};
      id_dest    = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
   end

   // Load-use hazard against the instruction currently held in the stage
   always_comb begin
      hazard_stall = ex_valid && ex_ctrl[EX_CTRL_MEM_READ] && (ex_rt != '0) && id_valid &&
                     ((ex_rt == id_rs) || ((ex_rt == id_rt) && dec_uses_rt));
   end

   // Bubble conditions below stall in priority; flush and rst are handled first
   always_comb begin
      load_bubble = hazard_stall || !id_valid;
   end

   // Stage register: rst > flush > stall (hold) > hazard/invalid bubble > load
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && load_bubble)) begin
         ex_valid   <= 1'b0;
         ex_alu_sel <= '0;
         ex_ctrl    <= '0;
         ex_branch  <= 1'b0;
         ex_illegal <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_dest    <= '0;
         ex_alu_src <= 1'b0;
      end else if (!stall) begin
         ex_valid   <= 1'b1;
         ex_alu_sel <= dec_sel;
         ex_ctrl    <= id_ctrl[CTRL_REG_WRITE:CTRL_MEM_TO_REG];
         ex_branch  <= dec_branch;
         ex_illegal <= dec_illegal;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm     <= id_imm_ext;
         ex_dest    <= id_dest;
         ex_alu_src <= id_ctrl[CTRL_ALU_SRC];
      end
   end

   // rs forwarding: EX/MEM first, then MEM/WB; r0 never forwards
   always_comb begin
      fwd_rs = ex_rs_data;
      if (ex_rs != '0) begin
         if (exm_wr_en && (exm_wr_addr == ex_rs))
            fwd_rs = exm_wr_data;
         else if (mwb_wr_en && (mwb_wr_addr == ex_rs))
            fwd_rs = mwb_wr_data;
      end
   end

   // rt forwarding: EX/MEM first, then MEM/WB; r0 never forwards
   always_comb begin
      fwd_rt = ex_rt_data;
      if (ex_rt != '0) begin
         if (exm_wr_en && (exm_wr_addr == ex_rt))
            fwd_rt = exm_wr_data;
         else if (mwb_wr_en && (mwb_wr_addr == ex_rt))
            fwd_rt = mwb_wr_data;
      end
   end

   // Operand selection for the ALU and the store path
   always_comb begin
      ex_op1        = fwd_rs;
      ex_op2        = ex_alu_src ? ex_imm : fwd_rt;
      ex_store_data = fwd_rt;
   end

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Directed self-checking bench for id_ex_alu_feed.
module tb_id_ex_alu_feed;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [5:0]        id_opcode, id_funct;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic [DATA_W-1:0] id_rs_data, id_rt_data;
   logic [15:0]       id_imm16;
   logic [5:0]        id_ctrl;
   logic              stall, flush;
   logic              exm_wr_en, mwb_wr_en;
   logic [REG_AW-1:0] exm_wr_addr, mwb_wr_addr;
   logic [DATA_W-1:0] exm_wr_data, mwb_wr_data;
   logic              hazard_stall, ex_valid, ex_branch, ex_illegal;
   logic [3:0]        ex_alu_sel, ex_ctrl;
   logic [DATA_W-1:0] ex_op1, ex_op2, ex_store_data;
   logic [REG_AW-1:0] ex_dest;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_alu_feed #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm16(id_imm16), .id_ctrl(id_ctrl), .stall(stall), .flush(flush),
      .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data),
      .mwb_wr_en(mwb_wr_en), .mwb_wr_addr(mwb_wr_addr), .mwb_wr_data(mwb_wr_data),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_sel(ex_alu_sel),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .ex_ctrl(ex_ctrl), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src}
   localparam logic [5:0] C_RTYPE = 6'b100010;
   localparam logic [5:0] C_IMM   = 6'b100001;
   localparam logic [5:0] C_LW    = 6'b110101;
   localparam logic [5:0] C_SW    = 6'b001001;
   localparam logic [5:0] C_BEQ   = 6'b000000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [15:0] imm, input logic [5:0] ctl);
      id_valid = 1'b1; id_opcode = op; id_funct = fn;
      id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm; id_ctrl = ctl;
   endtask

   task automatic wb_off();
      exm_wr_en = 1'b0; exm_wr_addr = '0; exm_wr_data = '0;
      mwb_wr_en = 1'b0; mwb_wr_addr = '0; mwb_wr_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_off();
      drive_id(6'b000000, 6'b100000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'h0000, C_RTYPE);
      tick(); tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
      checks++; if (ex_alu_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got=%b exp=0000", ex_alu_sel); end
      checks++; if (ex_ctrl !== 4'b0000 || ex_branch !== 1'b0 || ex_illegal !== 1'b0)
         begin errors++; $display("FAIL reset_flags got ctrl=%b br=%b ill=%b exp=0", ex_ctrl, ex_branch, ex_illegal); end
      checks++; if (ex_op1 !== 32'd0 || ex_op2 !== 32'd0 || ex_store_data !== 32'd0 || ex_dest !== 5'd0)
         begin errors++; $display("FAIL reset_data got op1=%h op2=%h st=%h dest=%0d exp=0", ex_op1, ex_op2, ex_store_data, ex_dest); end
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard_stall); end
      rst = 1'b0;
   endtask

   task automatic test_rtype_add();
      drive_id(6'b000000, 6'b100000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'h1234, C_RTYPE);
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_alu_sel !== 4'b0010)
         begin errors++; $display("FAIL add_sel got v=%b sel=%b exp v=1 sel=0010", ex_valid, ex_alu_sel); end
      checks++; if (ex_op1 !== 32'd5 || ex_op2 !== 32'd7 || ex_store_data !== 32'd7)
         begin errors++; $display("FAIL add_ops got op1=%0d op2=%0d st=%0d exp 5 7 7", ex_op1, ex_op2, ex_store_data); end
      checks++; if (ex_dest !== 5'd8 || ex_ctrl !== 4'b1000)
         begin errors++; $display("FAIL add_dest got dest=%0d ctrl=%b exp 8 1000", ex_dest, ex_ctrl); end
      // NOR via funct 100111
      drive_id(6'b000000, 6'b100111, 5'd1, 5'd2, 5'd3, 32'h0F, 32'hF0, 16'h0000, C_RTYPE);
      tick();
      checks++; if (ex_alu_sel !== 4'b1100) begin errors++; $display("FAIL nor_sel got=%b exp=1100", ex_alu_sel); end
   endtask

   task automatic test_immediate();
      drive_id(6'b001000, 6'b000000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'hFFFF, C_IMM);
      tick();
      checks++; if (ex_op2 !== 32'hFFFF_FFFF || ex_alu_sel !== 4'b0010)
         begin errors++; $display("FAIL addi_sext got op2=%h sel=%b exp ffffffff 0010", ex_op2, ex_alu_sel); end
      checks++; if (ex_dest !== 5'd4 || ex_store_data !== 32'd7)
         begin errors++; $display("FAIL addi_dest got dest=%0d st=%0d exp 4 7", ex_dest, ex_store_data); end
      drive_id(6'b001100, 6'b000000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'hFFFF, C_IMM);
      tick();
      checks++; if (ex_op2 !== 32'h0000_FFFF || ex_alu_sel !== 4'b0000)
         begin errors++; $display("FAIL andi_zext got op2=%h sel=%b exp 0000ffff 0000", ex_op2, ex_alu_sel); end
      drive_id(6'b001101, 6'b000000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'h8001, C_IMM);
      tick();
      checks++; if (ex_op2 !== 32'h0000_8001 || ex_alu_sel !== 4'b0001)
         begin errors++; $display("FAIL ori_zext got op2=%h sel=%b exp 00008001 0001", ex_op2, ex_alu_sel); end
      drive_id(6'b001010, 6'b000000, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 16'h8000, C_IMM);
      tick();
      checks++; if (ex_op2 !== 32'hFFFF_8000 || ex_alu_sel !== 4'b0111)
         begin errors++; $display("FAIL slti_sext got op2=%h sel=%b exp ffff8000 0111", ex_op2, ex_alu_sel); end
   endtask

   task automatic test_forwarding();
      drive_id(6'b000000, 6'b100010, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 16'h0000, C_RTYPE);
      tick();
      checks++; if (ex_op1 !== 32'h11 || ex_alu_sel !== 4'b0110)
         begin errors++; $display("FAIL fwd_base got op1=%h sel=%b exp 11 0110", ex_op1, ex_alu_sel); end
      exm_wr_en = 1'b1; exm_wr_addr = 5'd5; exm_wr_data = 32'hAA;
      mwb_wr_en = 1'b1; mwb_wr_addr = 5'd5; mwb_wr_data = 32'hBB;
      #1;
      checks++; if (ex_op1 !== 32'hAA) begin errors++; $display("FAIL fwd_exm_prio got=%h exp=aa", ex_op1); end
      exm_wr_en = 1'b0;
      #1;
      checks++; if (ex_op1 !== 32'hBB) begin errors++; $display("FAIL fwd_mwb got=%h exp=bb", ex_op1); end
      mwb_wr_addr = 5'd6; mwb_wr_data = 32'hCC;
      #1;
      checks++; if (ex_op2 !== 32'hCC || ex_store_data !== 32'hCC || ex_op1 !== 32'h11)
         begin errors++; $display("FAIL fwd_rt got op2=%h st=%h op1=%h exp cc cc 11", ex_op2, ex_store_data, ex_op1); end
      wb_off();
      drive_id(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 16'h0000, C_RTYPE);
      tick();
      exm_wr_en = 1'b1; exm_wr_addr = 5'd0; exm_wr_data = 32'hAA;
      mwb_wr_en = 1'b1; mwb_wr_addr = 5'd0; mwb_wr_data = 32'hBB;
      #1;
      checks++; if (ex_op1 !== 32'h33 || ex_op2 !== 32'h44)
         begin errors++; $display("FAIL fwd_r0 got op1=%h op2=%h exp 33 44", ex_op1, ex_op2); end
      wb_off();
   endtask

   task automatic test_load_use();
      drive_id(6'b100011, 6'b000000, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 16'h0004, C_LW);
      tick();
      checks++; if (ex_ctrl !== 4'b1101 || ex_dest !== 5'd9 || ex_op2 !== 32'd4)
         begin errors++; $display("FAIL lw_stage got ctrl=%b dest=%0d op2=%h exp 1101 9 4", ex_ctrl, ex_dest, ex_op2); end
      drive_id(6'b000000, 6'b100000, 5'd9, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000, C_RTYPE);
      #1;
      checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_rs got=%b exp=1", hazard_stall); end
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 4'b0000 || ex_op1 !== 32'd0)
         begin errors++; $display("FAIL lu_bubble got v=%b ctrl=%b op1=%h exp 0 0000 0", ex_valid, ex_ctrl, ex_op1); end
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", hazard_stall); end
      drive_id(6'b100011, 6'b000000, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 16'h0004, C_LW);
      tick();
      drive_id(6'b001000, 6'b000000, 5'd2, 5'd9, 5'd0, 32'h1, 32'h2, 16'h0001, C_IMM);
      #1;
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_addi_rt got=%b exp=0", hazard_stall); end
      drive_id(6'b101011, 6'b000000, 5'd2, 5'd9, 5'd0, 32'h1, 32'h2, 16'h0000, C_SW);
      #1;
      checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_sw_rt got=%b exp=1", hazard_stall); end
      id_valid = 1'b0;
      #1;
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_id_invalid got=%b exp=0", hazard_stall); end
      // held under stall: hazard persists against the held lw
      drive_id(6'b000000, 6'b100000, 5'd9, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000, C_RTYPE);
      stall = 1'b1;
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 4'b1101 || hazard_stall !== 1'b1)
         begin errors++; $display("FAIL lu_stall_hold got v=%b ctrl=%b hz=%b exp 1 1101 1", ex_valid, ex_ctrl, hazard_stall); end
      stall = 1'b0;
      tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_after_stall got v=%b exp=0", ex_valid); end
   endtask

   task automatic test_priority();
      drive_id(6'b000000, 6'b100000, 5'd5, 5'd6, 5'd7, 32'h10, 32'h20, 16'h0000, C_RTYPE);
      tick();
      stall = 1'b1;
      drive_id(6'b000000, 6'b100010, 5'd3, 5'd4, 5'd2, 32'h99, 32'h98, 16'h0000, C_RTYPE);
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_alu_sel !== 4'b0010 || ex_op1 !== 32'h10 || ex_dest !== 5'd7)
         begin errors++; $display("FAIL stall_hold got v=%b sel=%b op1=%h dest=%0d exp 1 0010 10 7", ex_valid, ex_alu_sel, ex_op1, ex_dest); end
      exm_wr_en = 1'b1; exm_wr_addr = 5'd5; exm_wr_data = 32'h77;
      #1;
      checks++; if (ex_op1 !== 32'h77) begin errors++; $display("FAIL stall_fwd got=%h exp=77", ex_op1); end
      wb_off();
      flush = 1'b1;
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_alu_sel !== 4'b0000 || ex_dest !== 5'd0)
         begin errors++; $display("FAIL flush_over_stall got v=%b sel=%b dest=%0d exp 0 0000 0", ex_valid, ex_alu_sel, ex_dest); end
      stall = 1'b0; flush = 1'b0;
      drive_id(6'b000100, 6'b000000, 5'd5, 5'd6, 5'd0, 32'h10, 32'h20, 16'h0003, C_BEQ);
      tick();
      checks++; if (ex_branch !== 1'b1 || ex_alu_sel !== 4'b0110 || ex_op2 !== 32'h20)
         begin errors++; $display("FAIL beq got br=%b sel=%b op2=%h exp 1 0110 20", ex_branch, ex_alu_sel, ex_op2); end
      rst = 1'b1; flush = 1'b1;
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_branch !== 1'b0 || ex_alu_sel !== 4'b0000 || ex_ctrl !== 4'b0000 ||
                    ex_op1 !== 32'd0 || ex_op2 !== 32'd0 || ex_store_data !== 32'd0 || ex_illegal !== 1'b0)
         begin errors++; $display("FAIL rst_flush got v=%b br=%b sel=%b ctrl=%b op1=%h op2=%h st=%h ill=%b exp all 0",
                                  ex_valid, ex_branch, ex_alu_sel, ex_ctrl, ex_op1, ex_op2, ex_store_data, ex_illegal); end
      rst = 1'b0; flush = 1'b0;
   endtask

   task automatic test_illegal();
      drive_id(6'b111111, 6'b000000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000, C_IMM);
      tick();
      checks++; if (ex_alu_sel !== 4'b1111 || ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ex_ctrl !== 4'b1000)
         begin errors++; $display("FAIL ill_opcode got sel=%b ill=%b v=%b ctrl=%b exp 1111 1 1 1000", ex_alu_sel, ex_illegal, ex_valid, ex_ctrl); end
      drive_id(6'b000000, 6'b000000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000, C_RTYPE);
      tick();
      checks++; if (ex_alu_sel !== 4'b1111 || ex_illegal !== 1'b1)
         begin errors++; $display("FAIL ill_funct got sel=%b ill=%b exp 1111 1", ex_alu_sel, ex_illegal); end
      drive_id(6'b000000, 6'b101010, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000, C_RTYPE);
      tick();
      checks++; if (ex_alu_sel !== 4'b0111 || ex_illegal !== 1'b0)
         begin errors++; $display("FAIL slt_legal got sel=%b ill=%b exp 0111 0", ex_alu_sel, ex_illegal); end
      id_valid = 1'b0;
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_alu_sel !== 4'b0000 || ex_op1 !== 32'd0)
         begin errors++; $display("FAIL id_invalid got v=%b sel=%b op1=%h exp 0 0000 0", ex_valid, ex_alu_sel, ex_op1); end
   endtask

   initial begin
      test_reset();
      test_rtype_add();
      test_immediate();
      test_forwarding();
      test_load_use();
      test_priority();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
